instr_encoder: RTL

//  Packs decoded RV64I/M instruction fields (type, opcode, func3/func7, rd/rs1/rs2, immediate) into 32-bit instruction words.
//  It is the inverse of the fetch-side decoder. It feeds the instruction-stream generator for self-checking benches and the

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/instr_encoder_if.sv | 31 +++
 rtl/instr_encoder_imm_packer.sv | 74 +++++++
 rtl/instr_encoder.sv | 102 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64I/M encoding types: instruction-type enum, major opcodes, field bundle and small helpers.
package riscv_pkg;

    typedef enum logic [3:0] {
        NOTYPE = 4'd0,
        RTYPE  = 4'd1,
        ITYPE  = 4'd2,
        STYPE  = 4'd3,
        SBTYPE = 4'd4,
        UTYPE  = 4'd5,
        UJTYPE = 4'd6
    } instr_type_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_R64    = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM64  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [3:0]  itype;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_fields_t;

    // Immediate-form shifts carry a shamt instead of a 12-bit immediate.
    function automatic logic is_shift(input logic [6:0] opcode, input logic [2:0] func3);
        return ((opcode == OP_IMM) || (opcode == OP_IMM64)) &&
               ((func3 == 3'b001) || (func3 == 3'b101));
    endfunction

    function automatic logic fits_signed(input logic [31:0] value, input int bits);
        int lim;
        lim = 1 << (bits - 1);
        return ($signed(value) >= -lim) && ($signed(value) < lim);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshake of the instruction encoder.
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_type;
    logic [6:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_type, in_opcode, in_func3, in_func7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_func3, in_func7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/instr_encoder_imm_packer.sv
// Scatters the immediate (or shift func7/shamt) into its word positions and flags unencodable bundles.
// Range checking of the immediate is compiled in only when ENC_RANGE_CHECK_EN is defined.
module imm_packer
    import riscv_pkg::*;
(
    input  logic [3:0]  itype,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [5:0]  func7_hi,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        err
);

    logic type_err;
    logic range_err;

    always_comb begin
        imm_bits = '0;
        type_err = 1'b0;
        case (itype)
            RTYPE: ;
            ITYPE: begin
                if (is_shift(opcode, func3))
                    imm_bits[31:20] = {func7_hi, imm[5:0]};
                else
                    imm_bits[31:20] = imm[11:0];
            end
            STYPE: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
            end
            SBTYPE: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
            end
            UTYPE: imm_bits[31:12] = imm[31:12];
            UJTYPE: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
            end
            default: type_err = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Out-of-range immediates are still emitted truncated; only the flag reports them.
    always_comb begin
        range_err = 1'b0;
        case (itype)
            ITYPE: begin
                if (is_shift(opcode, func3))
                    range_err = |imm[31:6];
                else
                    range_err = !fits_signed(imm, 12);
            end
            STYPE:  range_err = !fits_signed(imm, 12);
            SBTYPE: range_err = !fits_signed(imm, 13) || imm[0];
            UTYPE:  range_err = |imm[11:0];
            UJTYPE: range_err = !fits_signed(imm, 21) || imm[0];
            default: range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = type_err | range_err;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder packing decoded RV64I/M fields into 32-bit words, with handoff counters.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    enc_fields_t s1_q;
    logic        s1_v;
    logic        s2_v;
    logic [31:0] s2_instr;
    logic        s2_err;
    logic        s1_adv;
    logic        handoff;
    logic        accept;
    logic [31:0] imm_bits;
    logic        imm_err;
    logic [31:0] reg_bits;
    logic        is_nop;
    logic [31:0] packed_word;

    // S1 drains whenever S2 is empty or is being emptied this cycle.
    assign s1_adv       = s1_v & (~s2_v | bus.out_ready);
    assign handoff      = s2_v & bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.in_ready = ~s1_v | s1_adv;
    assign bus.out_valid = s2_v;
    assign bus.out_instr = s2_instr;
    assign bus.out_err   = s2_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (accept) begin
            s1_v <= 1'b1;
            s1_q <= '{itype:  bus.in_type,  opcode: bus.in_opcode,
                      func3:  bus.in_func3, func7:  bus.in_func7,
                      rd:     bus.in_rd,    rs1:    bus.in_rs1,
                      rs2:    bus.in_rs2,   imm:    bus.in_imm};
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    imm_packer u_imm_packer (
        .itype    (s1_q.itype),
        .opcode   (s1_q.opcode),
        .func3    (s1_q.func3),
        .func7_hi (s1_q.func7[6:1]),
        .imm      (s1_q.imm),
        .imm_bits (imm_bits),
        .err      (imm_err)
    );

    always_comb begin
        reg_bits = '0;
        is_nop   = 1'b0;
        case (s1_q.itype)
            RTYPE:          reg_bits = {s1_q.func7, s1_q.rs2, s1_q.rs1, s1_q.func3, s1_q.rd, s1_q.opcode};
            ITYPE:          reg_bits = {12'b0, s1_q.rs1, s1_q.func3, s1_q.rd, s1_q.opcode};
            STYPE, SBTYPE:  reg_bits = {7'b0, s1_q.rs2, s1_q.rs1, s1_q.func3, 5'b0, s1_q.opcode};
            UTYPE, UJTYPE:  reg_bits = {20'b0, s1_q.rd, s1_q.opcode};
            default:        is_nop   = 1'b1;
        endcase
        packed_word = is_nop ? NOP_WORD : (reg_bits | imm_bits);
    end

    // A new load takes priority over clearing, so back-to-back words never leave a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_v     <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_v     <= 1'b1;
            s2_instr <= packed_word;
            s2_err   <= imm_err;
        end else if (handoff) begin
            s2_v     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (handoff) begin
            enc_count <= enc_count + CNT_W'(1);
            if (s2_err)
                err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
